// File: rtl/pin_entry_ctrl.sv
// Two-button PIN front end: conditions raw button levels, assembles a 4-digit
// BCD entry, stores the first entry as reference and verifies later ones.
module pin_entry_ctrl #(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        b_esq_i,
    input  logic        b_dir_i,
    input  logic        lock_i,
    output logic [3:0]  digit_o,
    output logic [1:0]  digit_idx_o,
    output logic [15:0] pin_vec_o,
    output logic        pin_set_o,
    output logic        unlock_o,
    output logic        fail_o,
    output logic [3:0]  fail_cnt_o,
    output logic        locked_out_o
);

    localparam int              CW       = $clog2(LOCK_CYCLES);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LOCK_CYCLES - 1);
    localparam logic [3:0]      MAX_CNT  = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_SETUP,
        ST_VERIFY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     digit_q, digit_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    entry_q, entry_d;
    logic [15:0]    pin_q, pin_d;
    logic           pin_set_q, pin_set_d;
    logic           unlock_q, unlock_d;
    logic           fail_q, fail_d;
    logic [3:0]     fail_cnt_q, fail_cnt_d;
    logic           locked_q, locked_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [1:0]     esq_sync_q, dir_sync_q;
    logic           esq_hist_q, dir_hist_q;
    logic           esq_evt, dir_evt, inc_evt, cfm_evt;

    // Synchronizers keep running in every state so a button held through an
    // ignored phase cannot produce a late event when editing resumes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            esq_sync_q <= 2'b00;
            dir_sync_q <= 2'b00;
            esq_hist_q <= 1'b0;
            dir_hist_q <= 1'b0;
        end else begin
            esq_sync_q <= {esq_sync_q[0], b_esq_i};
            dir_sync_q <= {dir_sync_q[0], b_dir_i};
            esq_hist_q <= esq_sync_q[1];
            dir_hist_q <= dir_sync_q[1];
        end
    end

    assign esq_evt = esq_sync_q[1] & ~esq_hist_q;
    assign dir_evt = dir_sync_q[1] & ~dir_hist_q;
    assign inc_evt = dir_evt & ~esq_evt;
    assign cfm_evt = esq_evt & ~dir_evt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_SETUP;
            digit_q    <= 4'd0;
            idx_q      <= 2'd0;
            entry_q    <= 16'd0;
            pin_q      <= 16'd0;
            pin_set_q  <= 1'b0;
            unlock_q   <= 1'b0;
            fail_q     <= 1'b0;
            fail_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            idx_q      <= idx_d;
            entry_q    <= entry_d;
            pin_q      <= pin_d;
            pin_set_q  <= pin_set_d;
            unlock_q   <= unlock_d;
            fail_q     <= fail_d;
            fail_cnt_q <= fail_cnt_d;
            locked_q   <= locked_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        idx_d      = idx_q;
        entry_d    = entry_q;
        pin_d      = pin_q;
        pin_set_d  = pin_set_q;
        unlock_d   = unlock_q;
        fail_d     = 1'b0;
        fail_cnt_d = fail_cnt_q;
        locked_d   = locked_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_SETUP, ST_VERIFY: begin
                if (inc_evt) begin
                    digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
                end else if (cfm_evt) begin
                    entry_d[{idx_q, 2'b00} +: 4] = digit_q;
                    digit_d = 4'd0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (state_q == ST_SETUP) begin
                            pin_d     = entry_d;
                            pin_set_d = 1'b1;
                            entry_d   = 16'd0;
                            state_d   = ST_VERIFY;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end

            ST_CHECK: begin
                digit_d = 4'd0;
                idx_d   = 2'd0;
                entry_d = 16'd0;
                if (entry_q == pin_q) begin
                    unlock_d   = 1'b1;
                    fail_cnt_d = 4'd0;
                    state_d    = ST_UNLOCKED;
                end else begin
                    fail_d     = 1'b1;
                    fail_cnt_d = fail_cnt_q + 4'd1;
                    if (fail_cnt_d == MAX_CNT) begin
                        locked_d = 1'b1;
                        cnt_d    = CNT_LOAD;
                        state_d  = ST_LOCKOUT;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end

            ST_UNLOCKED: begin
                if (lock_i) begin
                    unlock_d = 1'b0;
                    state_d  = ST_VERIFY;
                end
            end

            ST_LOCKOUT: begin
                // Loaded with LOCK_CYCLES-1 so the zero cycle completes the window.
                if (cnt_q == '0) begin
                    locked_d   = 1'b0;
                    fail_cnt_d = 4'd0;
                    state_d    = ST_VERIFY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = ST_SETUP;
        endcase
    end

    assign digit_o      = digit_q;
    assign digit_idx_o  = idx_q;
    assign pin_vec_o    = pin_q;
    assign pin_set_o    = pin_set_q;
    assign unlock_o     = unlock_q;
    assign fail_o       = fail_q;
    assign fail_cnt_o   = fail_cnt_q;
    assign locked_out_o = locked_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: directed scenarios plus random PIN entries, checked
// against a press-level model of the PIN entry rules.
module tb_pin_entry_ctrl;

    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        b_esq = 1'b0;
    logic        b_dir = 1'b0;
    logic        lock = 1'b0;
    logic [3:0]  digit_o;
    logic [1:0]  digit_idx_o;
    logic [15:0] pin_vec_o;
    logic        pin_set_o;
    logic        unlock_o;
    logic        fail_o;
    logic [3:0]  fail_cnt_o;
    logic        locked_out_o;

    pin_entry_ctrl #(.MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .b_esq_i     (b_esq),
        .b_dir_i     (b_dir),
        .lock_i      (lock),
        .digit_o     (digit_o),
        .digit_idx_o (digit_idx_o),
        .pin_vec_o   (pin_vec_o),
        .pin_set_o   (pin_set_o),
        .unlock_o    (unlock_o),
        .fail_o      (fail_o),
        .fail_cnt_o  (fail_cnt_o),
        .locked_out_o(locked_out_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = choosing reference, 1 = verifying, 2 = unlocked, 3 = locked out
    int m_mode;
    int m_digit;
    int m_idx;
    int m_entry[4];
    int m_ref[4];
    bit m_pin_set;
    int m_fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic logic [15:0] ref_vec();
        int v;
        v = 0;
        for (int k = 0; k < 4; k++) v += m_ref[k] * (1 << (4 * k));
        return 16'(v);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_digit = 0; m_idx = 0; m_pin_set = 0; m_fails = 0;
        for (int k = 0; k < 4; k++) begin
            m_entry[k] = 0;
            m_ref[k]   = 0;
        end
    endtask

    task automatic check_static(input string tag);
        chk({tag, ".digit"},    digit_o,      m_digit);
        chk({tag, ".idx"},      digit_idx_o,  m_idx);
        chk({tag, ".pin_set"},  pin_set_o,    m_pin_set);
        chk({tag, ".pin_vec"},  pin_vec_o,    m_pin_set ? ref_vec() : 16'd0);
        chk({tag, ".unlock"},   unlock_o,     m_mode == 2);
        chk({tag, ".locked"},   locked_out_o, m_mode == 3);
        chk({tag, ".fail_cnt"}, fail_cnt_o,   m_fails);
        chk({tag, ".fail"},     fail_o,       1'b0);
    endtask

    task automatic measure_lockout();
        int hi;
        hi = 0;
        for (int i = 0; i < 4 * LOCK_CYCLES; i++) begin
            if (!locked_out_o) break;
            hi++;
            if (i == 1) chk("lockout.fail_pulse_end", fail_o, 1'b0);
            chk("lockout.exclusive", unlock_o & locked_out_o, 1'b0);
            b_dir = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_esq = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        b_dir = 1'b0;
        b_esq = 1'b0;
        chk("lockout.length", hi, LOCK_CYCLES);
        m_mode  = 1;
        m_fails = 0;
        m_digit = 0;
        m_idx   = 0;
        idle(3);
        check_static("after_lockout");
    endtask

    // One button action: high for a single sampled edge, then low for two.
    task automatic press(input bit dir, input bit esq);
        bit result_pending;
        bit match;
        idle($urandom_range(0, 1));
        b_dir = dir;
        b_esq = esq;
        step();
        b_dir = 1'b0;
        b_esq = 1'b0;
        step();
        step();
        result_pending = 0;
        if ((m_mode == 0 || m_mode == 1) && (dir ^ esq)) begin
            if (dir) begin
                m_digit = (m_digit + 1) % 10;
            end else begin
                m_entry[m_idx] = m_digit;
                m_digit = 0;
                m_idx   = (m_idx + 1) % 4;
                if (m_idx == 0) begin
                    if (m_mode == 0) begin
                        for (int k = 0; k < 4; k++) m_ref[k] = m_entry[k];
                        m_pin_set = 1;
                        m_mode    = 1;
                    end else begin
                        result_pending = 1;
                    end
                end
            end
        end
        if (!result_pending) begin
            check_static("press");
        end else begin
            chk("check.unlock_early", unlock_o, 1'b0);
            chk("check.fail_early",   fail_o,   1'b0);
            step();
            match = 1;
            for (int k = 0; k < 4; k++) if (m_entry[k] != m_ref[k]) match = 0;
            if (match) begin
                m_fails = 0;
                m_mode  = 2;
            end else begin
                m_fails++;
                m_mode = (m_fails == MAX_TRIES) ? 3 : 1;
            end
            chk("result.unlock",   unlock_o,     match);
            chk("result.fail",     fail_o,       !match);
            chk("result.fail_cnt", fail_cnt_o,   m_fails);
            chk("result.locked",   locked_out_o, m_mode == 3);
            if (m_mode == 3) begin
                measure_lockout();
            end else begin
                step();
                check_static("post_result");
            end
        end
    endtask

    task automatic enter_digit(input int d);
        int n;
        n = d + (($urandom_range(0, 3) == 0) ? 10 : 0);
        repeat (n) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
    endtask

    task automatic enter_pin(input int d0, input int d1, input int d2, input int d3);
        enter_digit(d0);
        enter_digit(d1);
        enter_digit(d2);
        enter_digit(d3);
    endtask

    task automatic enter_wrong();
        int w0;
        w0 = (m_ref[0] + 1 + int'($urandom_range(0, 8))) % 10;
        enter_pin(w0, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
    endtask

    task automatic lock_pulse(input string tag);
        lock = 1'b1;
        step();
        lock = 1'b0;
        if (m_mode == 2) m_mode = 1;
        check_static(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_static("reset");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset state and reference entry
        do_reset();
        enter_pin(1, 2, 3, 4);
        chk("setup.pin_vec_4321", pin_vec_o, 16'h4321);
        chk("setup.pin_set", pin_set_o, 1'b1);
        lock_pulse("lock_in_verify");

        // Correct entry unlocks; buttons ignored while unlocked; relock and repeat
        enter_pin(1, 2, 3, 4);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        lock_pulse("relock1");
        enter_pin(1, 2, 3, 4);
        lock_pulse("relock2");

        // Wrap-around and held button
        repeat (11) press(1'b1, 1'b0);
        chk("wrap.digit_before_confirm", digit_o, 4'd1);
        press(1'b0, 1'b1);
        b_dir = 1'b1;
        repeat (50) step();
        b_dir = 1'b0;
        idle(2);
        m_digit = (m_digit + 1) % 10;
        check_static("hold");
        chk("hold.digit_one", digit_o, 4'd1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);

        // Clear the count, then three wrong entries into lockout
        enter_pin(1, 2, 3, 4);
        lock_pulse("relock3");
        repeat (3) enter_pin(0, 0, 0, 0);
        chk("lockout.cnt_cleared", fail_cnt_o, 4'd0);
        enter_pin(1, 2, 3, 4);
        lock_pulse("relock4");

        // Simultaneous presses ignored; two wrong then a correct entry
        enter_digit(5);
        press(1'b1, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk("simul.idx", digit_idx_o, 2'd1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        enter_wrong();
        chk("two_wrong.cnt_before", fail_cnt_o, 4'd2);
        enter_pin(1, 2, 3, 4);
        chk("two_wrong.cnt_cleared", fail_cnt_o, 4'd0);
        lock_pulse("relock5");

        // Random entries, correct or random digits
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                enter_pin(m_ref[0], m_ref[1], m_ref[2], m_ref[3]);
            else
                enter_pin($urandom_range(0, 9), $urandom_range(0, 9),
                          $urandom_range(0, 9), $urandom_range(0, 9));
            if (m_mode == 2) lock_pulse("rand_relock");
        end

        // Reset mid-entry discards the reference; new reference is used
        enter_digit(7);
        enter_digit(8);
        do_reset();
        enter_pin($urandom_range(0, 9), $urandom_range(0, 9),
                  $urandom_range(0, 9), $urandom_range(0, 9));
        enter_wrong();
        enter_pin(m_ref[0], m_ref[1], m_ref[2], m_ref[3]);
        chk("new_ref.unlock", unlock_o, 1'b1);
        lock_pulse("final_relock");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
